sram_march_bist: RTL and testbench
==================================

// Module: sram_march_bist
// PURPOSE
//  Built-in self-test controller for the 256x4 single-port SRAM. It runs a March C- sequence
//  through the SRAM's addr/data/write-enable port and compares every read against the expected value.
//  It reports pass/fail plus first-failure diagnostics.
//  It sits beside the SRAM. The test-mode mux that selects between the functional path and BIST is outside this block.
// PARAMETERS
//  AW            8   address width; the array holds 2**AW words
//  DW            4   data width
//  RD_LAT        1   SRAM read latency in cycles (0 or 1); read data is sampled RD_LAT cycles after the address is issued
//  STOP_ON_FAIL  0   1: finish on the first mismatch; 0: run the full sequence and keep the first failure
// PORTS
//  clk           in   1    system clock, rising edge
//  rst           in   1    synchronous, active-high reset
//  start         in   1    begins a run when the block is idle; ignored while busy
//  abort         in   1    ends a run and returns to IDLE next cycle; done stays 0
//  sram_addr     out  AW   SRAM address
//  sram_din      out  DW   SRAM write data
//  sram_wen      out  1    SRAM write enable, active high
//  sram_dout     in   DW   SRAM read data
//  busy          out  1    high while the sequence is running
//  done          out  1    level; set at end of run, cleared by the next accepted start or by rst
//  pass          out  1    valid when done=1; 1 = no mismatch seen
//  fail_addr     out  AW   address of the first mismatch
//  fail_elem     out  3    March element index (0..5) of the first mismatch
//  fail_syn      out  DW   expected XOR actual at the first mismatch
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; first-fail capture cleared.
//  March C- sequence (bg = all-zeros word, ~bg = all-ones word):
//    E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
//  States: IDLE -> WR -> RD -> RWAIT -> RW -> NEXT -> DONE
//  - start sampled high in IDLE: the next cycle has busy=1, done=0, E0, sram_addr=0, sram_wen=1.
//  - Write op: 1 cycle, sram_wen=1, sram_din = expected-after-write value.
//  - Read op: RD_LAT+1 cycles.
//    - sram_wen=0 and sram_addr held for all of them; sram_din holds the last write value.
//    - Compare happens on the last cycle (same cycle when RD_LAT=0).
//  - Cycles per address: E0 = 1; E1..E4 = RD_LAT+2; E5 = RD_LAT+1.
//    Total busy cycles = 2**AW * (4*RD_LAT + RD_LAT + 10); default = 3840.
//  - Address order: up runs 0 to 2**AW-1; down runs 2**AW-1 to 0.
//    - The end of an element is detected from a last-address flag, not from counter wrap.
//    - The next element starts on the following cycle with no idle cycles in between.
//  - Mismatch (sram_dout != expected):
//    - On the first mismatch only, capture fail_addr, fail_elem and fail_syn. Later mismatches do not overwrite them.
//    - The fail flag is sticky.
//    - If STOP_ON_FAIL=1, go to DONE on the next cycle; no further SRAM accesses.
//  - DONE: busy=0, done=1, pass = ~fail, sram_wen=0.
//    - Diagnostics hold until the next accepted start, which clears them.
//  - start asserted while busy is ignored.
//  - start and abort high in the same cycle: abort wins.
//  - abort or rst mid-run:
//    - sram_wen is 0 from the next cycle; no partial write is extended.
//    - abort gives busy=0, done=0, pass=0. rst clears all outputs.
// STRUCTURE
//  - Shared include sram_bist_defs.vh holds:
//    - state encodings
//    - element table constants: per element, direction, op count, expected read value, write value
//    - E0..E5 index localparams
//  - Sub-module sram_bist_addr_gen:
//    - AW-bit up/down counter with load-to-first-address, enable and a last-address flag
//    - instantiated once
//  - The FSM, element/op sequencing and compare/capture logic live in this module.
// TESTING
//  1. Fault-free SRAM model, RD_LAT=1, pulse start
//     -> busy high for exactly 3840 cycles, then done=1, pass=1, fail_syn=0.
//  2. Bit 2 of addr 0x35 stuck-at-0, STOP_ON_FAIL=0
//     -> done after 3840 cycles, pass=0, fail_addr=0x35, fail_elem=2, fail_syn=4'b0100.
//  3. Same fault, STOP_ON_FAIL=1
//     -> mismatch on busy cycle 1185; done=1 the next cycle; no sram_wen after the mismatch.
//  4. RD_LAT=0 with a fault-free model
//     -> 2560 busy cycles, pass=1; a 1-cycle read compares in the same cycle as the address.
//  5. Re-pulse start at busy cycle 500, then rst at cycle 1000
//     -> the start is ignored; the cycle after rst has all outputs 0, and a new start runs the full 3840 cycles.
//  6. abort at cycle 200, with start asserted in the same cycle
//     -> IDLE next cycle, busy=0, done=0, sram_wen=0; a later start runs cleanly to pass=1.

Source files
------------

// File: rtl/sram_march_bist_pkg.sv
// sram_march_bist_pkg: state encodings and March C- element table for the SRAM BIST
package sram_march_bist_pkg;
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RWAIT, S_DONE} state_t;
  localparam logic [2:0] E0 = 3'd0;
  localparam logic [2:0] E1 = 3'd1;
  localparam logic [2:0] E2 = 3'd2;
  localparam logic [2:0] E3 = 3'd3;
  localparam logic [2:0] E4 = 3'd4;
  localparam logic [2:0] E5 = 3'd5;
  localparam logic [7:0] EL_DOWN = 8'b0001_1000;
  localparam logic [7:0] EL_RD   = 8'b0011_1110;
  localparam logic [7:0] EL_WR   = 8'b0001_1111;
  localparam logic [7:0] EL_RVAL = 8'b0001_0100;
  localparam logic [7:0] EL_WVAL = 8'b0000_1010;
  function automatic state_t first_state(input logic [2:0] e);
    return EL_RD[e] ? S_RD : S_WR;
  endfunction
endpackage

// File: rtl/sram_march_bist_addr_gen.sv
// sram_march_bist_addr_gen: up/down address counter with load-to-first-address and last-address flag
module sram_march_bist_addr_gen #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          load_down,
  input  logic          en,
  output logic [AW-1:0] addr,
  output logic          last
);
  logic down;
  // direction is latched on load so the element walks one way until the next load
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      down <= 1'b0;
    end else if (load) begin
      addr <= load_down ? '1 : '0;
      down <= load_down;
    end else if (en) begin
      addr <= down ? addr - AW'(1) : addr + AW'(1);
    end
  end
  assign last = down ? (addr == '0) : (addr == '1);
endmodule

// File: rtl/sram_march_bist.sv
// sram_march_bist: March C- BIST controller with first-failure capture
module sram_march_bist
  import sram_march_bist_pkg::*;
#(
  parameter int AW = 8,
  parameter int DW = 4,
  parameter int RD_LAT = 1,
  parameter int STOP_ON_FAIL = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_din,
  output logic          sram_wen,
  input  logic [DW-1:0] sram_dout,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [AW-1:0] fail_addr,
  output logic [2:0]    fail_elem,
  output logic [DW-1:0] fail_syn
);
  state_t state, state_n;
  logic [2:0] elem, elem_n, elem_nx;
  logic [DW-1:0] wval, rval, last_w;
  logic fail, cmp, mism, start_ok, step;
  logic ag_load, ag_load_down, ag_en, ag_last;
  sram_march_bist_addr_gen #(.AW(AW)) u_addr_gen (
    .clk(clk),
    .rst(rst),
    .load(ag_load),
    .load_down(ag_load_down),
    .en(ag_en),
    .addr(sram_addr),
    .last(ag_last)
  );
  assign elem_nx  = elem + 3'd1;
  assign wval     = {DW{EL_WVAL[elem]}};
  assign rval     = {DW{EL_RVAL[elem]}};
  assign cmp      = (state == S_RWAIT) || (state == S_RD && RD_LAT == 0);
  assign mism     = cmp && (sram_dout != rval);
  assign start_ok = start && !abort && (state == S_IDLE || state == S_DONE);
  assign busy     = state == S_WR || state == S_RD || state == S_RWAIT;
  assign done     = state == S_DONE;
  assign pass     = done && !fail;
  assign sram_wen = state == S_WR;
  assign sram_din = sram_wen ? wval : last_w;
  // sequencing: abort beats start, early stop beats normal stepping; elements chain with no gap
  always_comb begin
    state_n      = state;
    elem_n       = elem;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_en        = 1'b0;
    step         = 1'b0;
    if (abort) begin
      state_n = S_IDLE;
    end else if (start_ok) begin
      state_n      = S_WR;
      elem_n       = E0;
      ag_load      = 1'b1;
      ag_load_down = EL_DOWN[E0];
    end else if (mism && STOP_ON_FAIL != 0) begin
      state_n = S_DONE;
    end else begin
      step = state == S_WR || (cmp && !EL_WR[elem]);
      if (state == S_RD && RD_LAT != 0) state_n = S_RWAIT;
      else if (cmp && EL_WR[elem]) state_n = S_WR;
      if (step && ag_last) begin
        state_n      = elem == E5 ? S_DONE : first_state(elem_nx);
        elem_n       = elem == E5 ? elem : elem_nx;
        ag_load      = elem != E5;
        ag_load_down = EL_DOWN[elem_nx];
      end else if (step) begin
        state_n = first_state(elem);
        ag_en   = 1'b1;
      end
    end
  end
  // state, held write data and sticky first-failure capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      elem      <= E0;
      last_w    <= '0;
      fail      <= 1'b0;
      fail_addr <= '0;
      fail_elem <= '0;
      fail_syn  <= '0;
    end else begin
      state <= state_n;
      elem  <= elem_n;
      if (sram_wen) last_w <= wval;
      if (start_ok) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_elem <= '0;
        fail_syn  <= '0;
      end else if (mism) begin
        fail <= 1'b1;
        if (!fail) begin
          fail_addr <= sram_addr;
          fail_elem <= elem;
          fail_syn  <= rval ^ sram_dout;
        end
      end
    end
  end
endmodule

// File: tb/tb_sram_march_bist.sv
// tb_sram_march_bist: directed checks of the March C- BIST against small SRAM models
module tb_sram_march_bist;
  logic clk, rst, abort, fault;
  logic [2:0] start;
  logic [7:0] addr [3];
  logic [3:0] din [3];
  logic [3:0] dout [3];
  logic wen [3], busy [3], done [3], pass [3];
  logic [7:0] faddr [3];
  logic [2:0] felem [3];
  logic [3:0] fsyn [3];
  logic [3:0] mem0 [256], mem1 [256], mem2 [256];
  logic [3:0] q0, q1;
  int checks, passed;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  sram_march_bist #(.RD_LAT(1), .STOP_ON_FAIL(0)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort),
    .sram_addr(addr[0]), .sram_din(din[0]), .sram_wen(wen[0]), .sram_dout(dout[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]),
    .fail_addr(faddr[0]), .fail_elem(felem[0]), .fail_syn(fsyn[0])
  );
  sram_march_bist #(.RD_LAT(1), .STOP_ON_FAIL(1)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort),
    .sram_addr(addr[1]), .sram_din(din[1]), .sram_wen(wen[1]), .sram_dout(dout[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]),
    .fail_addr(faddr[1]), .fail_elem(felem[1]), .fail_syn(fsyn[1])
  );
  sram_march_bist #(.RD_LAT(0), .STOP_ON_FAIL(0)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .abort(abort),
    .sram_addr(addr[2]), .sram_din(din[2]), .sram_wen(wen[2]), .sram_dout(dout[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]),
    .fail_addr(faddr[2]), .fail_elem(felem[2]), .fail_syn(fsyn[2])
  );
  function automatic logic [3:0] wdat(input logic [7:0] a, input logic [3:0] d);
    return (fault && a == 8'h35) ? (d & 4'b1011) : d;
  endfunction
  always @(posedge clk) begin
    if (wen[0]) mem0[addr[0]] <= wdat(addr[0], din[0]);
    q0 <= mem0[addr[0]];
  end
  always @(posedge clk) begin
    if (wen[1]) mem1[addr[1]] <= wdat(addr[1], din[1]);
    q1 <= mem1[addr[1]];
  end
  always @(posedge clk) begin
    if (wen[2]) mem2[addr[2]] <= din[2];
  end
  assign dout[0] = q0;
  assign dout[1] = q1;
  assign dout[2] = mem2[addr[2]];

  task automatic pulse(input int i);
    @(negedge clk);
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
  endtask

  task automatic count_busy(input int i, output int n);
    n = 0;
    while (busy[i] && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({busy[i], done[i], pass[i], wen[i], addr[i], din[i], faddr[i], felem[i], fsyn[i]} !== 35'd0)
        $display("FAIL reset_outputs dut%0d got %h want 0", i,
                 {busy[i], done[i], pass[i], wen[i], addr[i], din[i], faddr[i], felem[i], fsyn[i]});
      else passed++;
    end
  endtask

  task automatic test_fault_free;
    int n;
    fault = 1'b0;
    pulse(0);
    checks++;
    if ({busy[0], done[0], wen[0], addr[0], din[0]} !== {1'b1, 1'b0, 1'b1, 8'h00, 4'h0})
      $display("FAIL first_cycle got b%b d%b w%b a%h din%h want b1 d0 w1 a00 din0",
               busy[0], done[0], wen[0], addr[0], din[0]);
    else passed++;
    count_busy(0, n);
    checks++;
    if (n !== 3840) $display("FAIL ff_busy_cycles got %0d want 3840", n); else passed++;
    checks++;
    if ({done[0], pass[0], fsyn[0]} !== {1'b1, 1'b1, 4'h0})
      $display("FAIL ff_result got done%b pass%b syn%h want done1 pass1 syn0", done[0], pass[0], fsyn[0]);
    else passed++;
  endtask

  task automatic test_stuck_full;
    int n;
    fault = 1'b1;
    pulse(0);
    count_busy(0, n);
    checks++;
    if (n !== 3840) $display("FAIL sa0_busy_cycles got %0d want 3840", n); else passed++;
    checks++;
    if ({done[0], pass[0]} !== 2'b10) $display("FAIL sa0_pass got done%b pass%b want done1 pass0", done[0], pass[0]);
    else passed++;
    checks++;
    if (faddr[0] !== 8'h35) $display("FAIL sa0_fail_addr got %h want 35", faddr[0]); else passed++;
    checks++;
    if (felem[0] !== 3'd2) $display("FAIL sa0_fail_elem got %0d want 2", felem[0]); else passed++;
    checks++;
    if (fsyn[0] !== 4'b0100) $display("FAIL sa0_fail_syn got %b want 0100", fsyn[0]); else passed++;
  endtask

  task automatic test_stop_on_fail;
    int n, wcount;
    fault = 1'b1;
    pulse(1);
    count_busy(1, n);
    checks++;
    if (n !== 1185) $display("FAIL sof_busy_cycles got %0d want 1185", n); else passed++;
    checks++;
    if ({done[1], pass[1]} !== 2'b10) $display("FAIL sof_done got done%b pass%b want done1 pass0", done[1], pass[1]);
    else passed++;
    wcount = 0;
    for (int k = 0; k < 5; k++) begin
      if (wen[1]) wcount++;
      @(negedge clk);
    end
    checks++;
    if (wcount !== 0) $display("FAIL sof_wen_after got %0d want 0", wcount); else passed++;
    checks++;
    if ({faddr[1], felem[1], fsyn[1]} !== {8'h35, 3'd2, 4'b0100})
      $display("FAIL sof_diag got a%h e%0d s%b want a35 e2 s0100", faddr[1], felem[1], fsyn[1]);
    else passed++;
  endtask

  task automatic test_rdlat0;
    int n;
    pulse(2);
    count_busy(2, n);
    checks++;
    if (n !== 2560) $display("FAIL lat0_busy_cycles got %0d want 2560", n); else passed++;
    checks++;
    if ({done[2], pass[2]} !== 2'b11) $display("FAIL lat0_pass got done%b pass%b want 11", done[2], pass[2]);
    else passed++;
  endtask

  task automatic test_restart_and_reset;
    int n;
    fault = 1'b0;
    pulse(0);
    n = 1;
    while (n < 500) begin
      @(negedge clk);
      n++;
    end
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    n++;
    checks++;
    if ({busy[0], wen[0], addr[0]} !== {1'b1, 1'b0, 8'd81})
      $display("FAIL restart_ignored got b%b w%b a%0d want b1 w0 a81", busy[0], wen[0], addr[0]);
    else passed++;
    while (n < 1000) begin
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({busy[0], done[0], pass[0], wen[0], addr[0], din[0], faddr[0], felem[0], fsyn[0]} !== 35'd0)
      $display("FAIL midrun_reset got %h want 0",
               {busy[0], done[0], pass[0], wen[0], addr[0], din[0], faddr[0], felem[0], fsyn[0]});
    else passed++;
    pulse(0);
    count_busy(0, n);
    checks++;
    if (n !== 3840) $display("FAIL after_rst_busy_cycles got %0d want 3840", n); else passed++;
    checks++;
    if (pass[0] !== 1'b1) $display("FAIL after_rst_pass got %b want 1", pass[0]); else passed++;
  endtask

  task automatic test_abort;
    int n;
    pulse(0);
    n = 1;
    while (n < 200) begin
      @(negedge clk);
      n++;
    end
    abort = 1'b1;
    start[0] = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start[0] = 1'b0;
    checks++;
    if ({busy[0], done[0], pass[0], wen[0]} !== 4'b0000)
      $display("FAIL abort_idle got b%b d%b p%b w%b want 0000", busy[0], done[0], pass[0], wen[0]);
    else passed++;
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0) $display("FAIL abort_start_dropped got busy %b want 0", busy[0]); else passed++;
    pulse(0);
    count_busy(0, n);
    checks++;
    if ({n, done[0], pass[0]} !== {32'd3840, 2'b11})
      $display("FAIL abort_rerun got n%0d d%b p%b want n3840 d1 p1", n, done[0], pass[0]);
    else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst = 1'b1;
    start = 3'b000;
    abort = 1'b0;
    fault = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b0;
    test_fault_free;
    test_stuck_full;
    test_stop_on_fail;
    test_rdlat0;
    test_restart_and_reset;
    test_abort;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
